// File: rtl/stack_sequencer.sv
// Stack sequencer: owns the stack pointer and expands one-shot stack requests
// into single-cycle memory accesses toward memory_stack.
module stack_sequencer #(
  parameter int STACK_TOP = 255,
  parameter int STACK_BOT = 200,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [3:0]        ccr_in,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  output logic              save_flags,
  output logic              restore_flags,
  output logic [ADDR_W-1:0] sp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] data_out,
  output logic [3:0]        ccr_out
);

  // state | meaning
  // IDLE  | waiting for req
  // WR1   | first write (data / PC)
  // WR2   | INTR flag write at sp-1
  // RD1   | read sp+1 (flags for RTI)
  // RD2   | RTI read of PC at sp+2
  // CAP   | capture popped value, done
  // FIN   | done (err=1 if rejected)
  typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2, CAP, FIN} state_t;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INTR = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  localparam logic [ADDR_W-1:0] SP_TOP      = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] SP_PUSH_MIN = ADDR_W'(STACK_BOT);
  localparam logic [ADDR_W-1:0] SP_INTR_MIN = ADDR_W'(STACK_BOT + 1);
  localparam logic [ADDR_W-1:0] SP_POP_MAX  = ADDR_W'(STACK_TOP - 1);
  localparam logic [ADDR_W-1:0] SP_RTI_MAX  = ADDR_W'(STACK_TOP - 2);
  localparam logic [ADDR_W-1:0] ONE         = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO         = ADDR_W'(2);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        ccr_q, ccr_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] data_out_q, data_out_d;
  logic [3:0]        ccr_out_q, ccr_out_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_data_q, mem_data_d;
  logic              save_q, save_d;
  logic              restore_q, restore_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    reg_d      = reg_q;
    pc_d       = pc_q;
    ccr_d      = ccr_q;
    sp_d       = sp_q;
    data_out_d = data_out_q;
    ccr_out_d  = ccr_out_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          op_d  = op;
          reg_d = reg_in;
          pc_d  = pc_in;
          ccr_d = ccr_in;
          case (op)
            OP_PUSH, OP_CALL: state_d = (sp_q >= SP_PUSH_MIN) ? WR1 : FIN;
            OP_INTR:          state_d = (sp_q >= SP_INTR_MIN) ? WR1 : FIN;
            OP_POP, OP_RET:   state_d = (sp_q <= SP_POP_MAX)  ? RD1 : FIN;
            OP_RTI:           state_d = (sp_q <= SP_RTI_MAX)  ? RD1 : FIN;
            default:          state_d = FIN;
          endcase
        end
      end
      WR1: begin
        if (op_q == OP_INTR) begin
          state_d = WR2;
        end else begin
          sp_d    = sp_q - ONE;
          state_d = FIN;
        end
      end
      WR2: begin
        sp_d    = sp_q - TWO;
        state_d = FIN;
      end
      RD1: state_d = (op_q == OP_RTI) ? RD2 : CAP;
      RD2: begin
        ccr_out_d = mem_rdata[3:0];
        state_d   = CAP;
      end
      CAP: begin
        data_out_d = mem_rdata;
        sp_d       = (op_q == OP_RTI) ? sp_q + TWO : sp_q + ONE;
        state_d    = IDLE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded for the state being entered so they come straight from flops.
    mem_en_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_data_d  = '0;
    save_d      = 1'b0;
    restore_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_d)
      WR1: begin
        mem_en_d    = 1'b1;
        mem_write_d = 1'b1;
        mem_addr_d  = sp_d;
        busy_d      = 1'b1;
        case (op_d)
          OP_PUSH: mem_data_d = reg_d;
          OP_CALL: mem_data_d = pc_d + ONE;
          default: mem_data_d = pc_d;
        endcase
      end
      WR2: begin
        mem_en_d    = 1'b1;
        mem_write_d = 1'b1;
        mem_addr_d  = sp_d - ONE;
        mem_data_d  = {{(ADDR_W-4){1'b0}}, ccr_d};
        save_d      = 1'b1;
        busy_d      = 1'b1;
      end
      RD1: begin
        mem_en_d   = 1'b1;
        mem_read_d = 1'b1;
        mem_addr_d = sp_d + ONE;
        restore_d  = (op_d == OP_RTI);
        busy_d     = 1'b1;
      end
      RD2: begin
        mem_en_d   = 1'b1;
        mem_read_d = 1'b1;
        mem_addr_d = sp_d + TWO;
        busy_d     = 1'b1;
      end
      CAP: done_d = 1'b1;
      FIN: begin
        done_d = 1'b1;
        // FIN is only reached straight from IDLE when the request is rejected.
        err_d  = (state_q == IDLE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      reg_q       <= '0;
      pc_q        <= '0;
      ccr_q       <= '0;
      sp_q        <= SP_TOP;
      data_out_q  <= '0;
      ccr_out_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      save_q      <= 1'b0;
      restore_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      pc_q        <= pc_d;
      ccr_q       <= ccr_d;
      sp_q        <= sp_d;
      data_out_q  <= data_out_d;
      ccr_out_q   <= ccr_out_d;
      mem_en_q    <= mem_en_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      save_q      <= save_d;
      restore_q   <= restore_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_en        = mem_en_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data_in   = mem_data_q;
  assign save_flags    = save_q;
  assign restore_flags = restore_q;
  assign sp            = sp_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign data_out      = data_out_q;
  assign ccr_out       = ccr_out_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: reference stack model predicts every memory access and
// completion into a queue; a negedge monitor pops and compares DUT activity.
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] reg_in = '0;
  logic [7:0] pc_in = '0;
  logic [3:0] ccr_in = '0;
  logic [7:0] mem_rdata = '0;
  logic       mem_en, mem_read, mem_write, save_flags, restore_flags;
  logic       busy, done, err;
  logic [7:0] mem_addr, mem_data_in, sp, data_out;
  logic [3:0] ccr_out;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .reg_in(reg_in), .pc_in(pc_in),
    .ccr_in(ccr_in), .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .save_flags(save_flags), .restore_flags(restore_flags), .sp(sp), .busy(busy),
    .done(done), .err(err), .data_out(data_out), .ccr_out(ccr_out)
  );

  always #5 clk = ~clk;

  // memory_stack stand-in: synchronous write, read data valid the cycle after mem_read
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en && mem_write) ram[mem_addr] <= mem_data_in;
    if (mem_en && mem_read)  mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 done
    logic [7:0] addr;
    logic [7:0] data;
    logic       sv;
    logic       rs;
    logic       er;
  } ev_t;
  ev_t exp_q[$];

  function automatic void exp_ev(int k, logic [7:0] a, logic [7:0] d, logic s, logic r, logic e);
    ev_t ev;
    ev.kind = k; ev.addr = a; ev.data = d; ev.sv = s; ev.rs = r; ev.er = e;
    exp_q.push_back(ev);
  endfunction

  always @(negedge clk) begin
    if (rst && (mem_write || mem_read || done)) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_event", {mem_write, mem_read, done}, 0);
      end else begin
        ev_t e;
        int  k;
        e = exp_q.pop_front();
        k = mem_write ? 0 : (mem_read ? 1 : 2);
        check_val("event_kind", k, e.kind);
        if (e.kind != 2) begin
          check_val("mem_en", mem_en, 1);
          check_val("mem_addr", mem_addr, e.addr);
          check_val("save_flags", save_flags, e.sv);
          check_val("restore_flags", restore_flags, e.rs);
          if (e.kind == 0) check_val("mem_data_in", mem_data_in, e.data);
        end else begin
          check_val("err", err, e.er);
          check_val("busy_at_done", busy, 0);
        end
      end
    end
  end

  // reference model
  logic [7:0] mdl [256];
  logic [7:0] sp_m = 8'd255;
  logic [7:0] exp_data = 8'h00;
  logic [3:0] exp_ccr = 4'h0;

  task automatic do_op(input logic [2:0] o, input logic [7:0] r, input logic [7:0] p,
                       input logic [3:0] c, input bit hold);
    bit rej;
    int exp_lat;
    int lat;
    bit seen;
    rej = 1'b0;
    exp_lat = 2;
    case (o)
      3'd0, 3'd2: begin
        if (sp_m < 8'd200) rej = 1'b1;
        else begin
          mdl[sp_m] = (o == 3'd0) ? r : p + 8'd1;
          exp_ev(0, sp_m, mdl[sp_m], 0, 0, 0);
          sp_m = sp_m - 8'd1;
        end
      end
      3'd4: begin
        if (sp_m < 8'd201) rej = 1'b1;
        else begin
          mdl[sp_m] = p;
          mdl[sp_m - 8'd1] = {4'h0, c};
          exp_ev(0, sp_m, p, 0, 0, 0);
          exp_ev(0, sp_m - 8'd1, {4'h0, c}, 1, 0, 0);
          sp_m = sp_m - 8'd2;
          exp_lat = 3;
        end
      end
      3'd1, 3'd3: begin
        if (sp_m > 8'd254) rej = 1'b1;
        else begin
          exp_ev(1, sp_m + 8'd1, 0, 0, 0, 0);
          exp_data = mdl[sp_m + 8'd1];
          sp_m = sp_m + 8'd1;
        end
      end
      3'd5: begin
        if (sp_m > 8'd253) rej = 1'b1;
        else begin
          exp_ev(1, sp_m + 8'd1, 0, 0, 1, 0);
          exp_ev(1, sp_m + 8'd2, 0, 0, 0, 0);
          exp_ccr = mdl[sp_m + 8'd1][3:0];
          exp_data = mdl[sp_m + 8'd2];
          sp_m = sp_m + 8'd2;
          exp_lat = 3;
        end
      end
      default: rej = 1'b1;
    endcase
    if (rej) exp_lat = 1;
    exp_ev(2, 0, 0, 0, 0, rej);

    @(posedge clk); #1;
    req = 1'b1; op = o; reg_in = r; pc_in = p; ccr_in = c;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      lat = n;
      if (n == 1) check_val("busy_cycle1", busy, !rej);
      if (done) seen = 1'b1;
      if (n == 1 && hold) begin
        @(posedge clk); #1;
        req = 1'b0;
      end
    end
    if (!seen) check_val("done_timeout", 0, 1);
    else check_val("latency", lat, exp_lat);
    @(negedge clk);
    check_val("done_pulse", done, 0);
    check_val("busy_idle", busy, 0);
    check_val("sp", sp, sp_m);
    check_val("data_out", data_out, exp_data);
    check_val("ccr_out", ccr_out, exp_ccr);
    check_val("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      mdl[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs",
              {mem_en, mem_read, mem_write, save_flags, restore_flags, busy, done, err}, 0);
    check_val("rst_sp", sp, 8'd255);
    check_val("rst_data_out", data_out, 0);
    check_val("rst_ccr_out", ccr_out, 0);
    @(negedge clk);
    rst = 1'b1;

    do_op(3'd0, 8'hA5, 8'h00, 4'h0, 0);   // PUSH A5
    do_op(3'd1, 8'h00, 8'h00, 4'h0, 0);   // POP -> A5
    do_op(3'd2, 8'h00, 8'hFF, 4'h0, 0);   // CALL wraps to 00
    do_op(3'd3, 8'h00, 8'h00, 4'h0, 0);   // RET -> 00
    do_op(3'd4, 8'h00, 8'h40, 4'hB, 0);   // INTR
    do_op(3'd5, 8'h00, 8'h00, 4'h0, 0);   // RTI -> 40 / B
    do_op(3'd1, 8'h00, 8'h00, 4'h0, 0);   // POP on empty -> err
    do_op(3'd6, 8'h11, 8'h22, 4'h3, 0);   // illegal
    do_op(3'd7, 8'h11, 8'h22, 4'h3, 0);   // illegal
    do_op(3'd0, 8'h5C, 8'h00, 4'h0, 1);   // PUSH with req held while busy
    do_op(3'd5, 8'h00, 8'h00, 4'h0, 0);   // RTI at sp=254 -> err
    do_op(3'd1, 8'h00, 8'h00, 4'h0, 0);   // POP -> 5C

    for (int i = 0; i < 55; i++) do_op(3'd0, 8'($urandom_range(0, 255)), 8'h00, 4'h0, 0);
    do_op(3'd4, 8'h00, 8'h99, 4'h7, 0);   // INTR at sp=200 -> err
    do_op(3'd0, 8'h3C, 8'h00, 4'h0, 0);   // 56th push -> sp=199
    do_op(3'd0, 8'hEE, 8'h00, 4'h0, 0);   // 57th push -> err
    do_op(3'd2, 8'h00, 8'h10, 4'h0, 0);   // CALL when full -> err
    for (int i = 0; i < 56; i++) do_op(3'd1, 8'h00, 8'h00, 4'h0, 0);

    // reset during INTR WR2
    exp_ev(0, 8'd255, 8'h77, 0, 0, 0);
    mdl[255] = 8'h77;
    @(posedge clk); #1;
    req = 1'b1; op = 3'd4; pc_in = 8'h77; ccr_in = 4'h5;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check_val("in_wr2", {mem_write, save_flags}, 2'b11);
    rst = 1'b0;
    #1;
    check_val("abort_outputs",
              {mem_en, mem_read, mem_write, save_flags, restore_flags, busy, done, err}, 0);
    check_val("abort_sp", sp, 8'd255);
    exp_q.delete();
    sp_m = 8'd255;
    exp_data = 8'h00;
    exp_ccr = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_sp", sp, 8'd255);
    check_val("post_rst_data_out", data_out, 0);
    do_op(3'd0, 8'h81, 8'h00, 4'h0, 0);
    do_op(3'd1, 8'h00, 8'h00, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
